// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : Receive buffer behind the uart core. Captures {error, byte} on each
//            rising edge of rx_ready into a first-word-fall-through FIFO, with
//            occupancy flags and a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int THRESH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic                     rx_error,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_err,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int                 c_AW        = $clog2(DEPTH);
    localparam logic [c_AW:0]      c_FULL_CNT  = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW:0]      c_THRESH    = (c_AW + 1)'(THRESH);
    localparam logic [c_AW:0]      c_ONE       = (c_AW + 1)'(1);
    localparam logic [c_AW-1:0]    c_PTR_ONE   = c_AW'(1);

    logic [8:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wp;
    logic [c_AW-1:0] r_rp;
    logic [c_AW:0]   r_count;
    logic            r_overflow;
    logic            r_rx_ready_q;

    logic            w_wr;
    logic            w_rd;
    logic            w_push;
    logic            w_drop;
    logic            w_empty;
    logic            w_full;
    logic [8:0]      w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL_CNT);

    // A held-high rx_ready yields a single strobe on its leading edge only.
    assign w_wr    = rx_ready & ~r_rx_ready_q;
    assign w_rd    = rd_en & ~w_empty;
    assign w_push  = w_wr & (~w_full | w_rd);
    assign w_drop  = w_wr & w_full & ~w_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_ready_q <= 1'b1;
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_rx_ready_q <= rx_ready;
            if (w_push) begin
                r_wp <= r_wp + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rp <= r_rp + c_PTR_ONE;
            end
            if (w_push && !w_rd) begin
                r_count <= r_count + c_ONE;
            end else if (w_rd && !w_push) begin
                r_count <= r_count - c_ONE;
            end
            // A drop in the same cycle as a clear must still be reported.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage is left unreset; the empty gating below hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wp] <= {rx_error, rx_data};
        end
    end

    assign w_head      = r_mem[r_rp];
    assign rd_data     = w_empty ? 8'h00 : w_head[7:0];
    assign rd_err      = w_empty ? 1'b0  : w_head[8];
    assign empty       = w_empty;
    assign full        = w_full;
    assign count       = r_count;
    assign almost_full = (r_count >= c_THRESH);
    assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int c_DEPTH  = 8;
    localparam int c_THRESH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b1;
    logic       rx_error = 1'b0;
    logic       rd_en = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_err;
    logic       empty;
    logic       full;
    logic [$clog2(c_DEPTH):0] count;
    logic       almost_full;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [8:0] m_q[$];
    bit       m_prev_rdy = 1'b1;
    bit       m_ovf = 1'b0;

    uart_rx_fifo #(.DEPTH(c_DEPTH), .THRESH(c_THRESH)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
        .rx_error(rx_error), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
        .empty(empty), .full(full), .count(count), .almost_full(almost_full),
        .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock: update the model from the driven inputs, then compare.
    task automatic tick();
        bit wr, rd, was_full, drop;
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_prev_rdy = 1'b1;
        end else begin
            wr = rx_ready && !m_prev_rdy;
            was_full = (m_q.size() == c_DEPTH);
            rd = rd_en && (m_q.size() != 0);
            drop = wr && was_full && !rd;
            if (rd) void'(m_q.pop_front());
            if (wr && !drop) m_q.push_back({rx_error, rx_data});
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_prev_rdy = rx_ready;
        end
        @(posedge clk);
        #1;
        check_val("count", 32'(count), 32'(m_q.size()));
        check_val("empty", 32'(empty), 32'(m_q.size() == 0));
        check_val("full", 32'(full), 32'(m_q.size() == c_DEPTH));
        check_val("almost_full", 32'(almost_full), 32'(m_q.size() >= c_THRESH));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("rd_data", 32'(rd_data), (m_q.size() == 0) ? 32'h0 : 32'(m_q[0][7:0]));
        check_val("rd_err", 32'(rd_err), (m_q.size() == 0) ? 32'h0 : 32'(m_q[0][8]));
    endtask

    task automatic push_byte(input logic [7:0] d, input logic e);
        rx_data = d; rx_error = e; rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        tick();
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        // Reset with rx_ready held high, then release: no write expected.
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        check_val("rel_empty", 32'(empty), 32'h1);
        check_val("rel_count", 32'(count), 32'h0);
        rx_ready = 1'b0;
        tick();
        rx_data = 8'hA5; rx_error = 1'b0; rx_ready = 1'b1;
        tick();
        check_val("a5_data", 32'(rd_data), 32'hA5);
        check_val("a5_err", 32'(rd_err), 32'h0);
        check_val("a5_count", 32'(count), 32'h1);
        rx_ready = 1'b0;
        tick();
        pop_one();

        // Held rx_ready produces one entry.
        rx_data = 8'h3C; rx_ready = 1'b1;
        repeat (5) tick();
        rx_ready = 1'b0;
        tick();
        check_val("held_count", 32'(count), 32'h1);
        pop_one();

        // Fill 01..08 with error on 04, then drain in order.
        for (int i = 1; i <= 8; i++) begin
            push_byte(8'(i), i == 4);
            check_val("fill_af", 32'(almost_full), 32'(i >= c_THRESH));
        end
        check_val("fill_full", 32'(full), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            check_val("drain_data", 32'(rd_data), 32'(i));
            check_val("drain_err", 32'(rd_err), 32'(i == 4));
            pop_one();
        end
        check_val("drain_empty", 32'(empty), 32'h1);

        // Overflow: drop, drop with clear (set wins), clear alone.
        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0);
        push_byte(8'hFF, 1'b0);
        check_val("ovf_set", 32'(overflow), 32'h1);
        check_val("ovf_count", 32'(count), 32'h8);
        check_val("ovf_head", 32'(rd_data), 32'h01);
        rx_data = 8'hEE; rx_ready = 1'b1; ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0; rx_ready = 1'b0;
        check_val("ovf_set_wins", 32'(overflow), 32'h1);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("ovf_clr", 32'(overflow), 32'h0);

        // Full + simultaneous write and pop.
        rx_data = 8'h99; rx_error = 1'b0; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        check_val("wrap_count", 32'(count), 32'h8);
        check_val("wrap_ovf", 32'(overflow), 32'h0);
        check_val("wrap_head", 32'(rd_data), 32'h02);
        tick();
        for (int i = 2; i <= 9; i++) begin
            check_val("wrap_data", 32'(rd_data), (i == 9) ? 32'h99 : 32'(i));
            pop_one();
        end

        // Pop on empty is ignored; write + pop on empty writes.
        pop_one();
        check_val("emp_pop", 32'(count), 32'h0);
        rx_data = 8'h5A; rx_ready = 1'b1; rd_en = 1'b1;
        tick();
        rx_ready = 1'b0; rd_en = 1'b0;
        check_val("emp_wr_rd", 32'(count), 32'h1);
        tick();
        push_byte(8'h11, 1'b1);
        rx_data = 8'h22; rx_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; rx_ready = 1'b0;
        check_val("rst_count", 32'(count), 32'h0);
        check_val("rst_empty", 32'(empty), 32'h1);
        check_val("rst_data", 32'(rd_data), 32'h0);
        tick();

        // Random traffic with varying pop pressure.
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 500; c++) begin
                rx_ready = ($urandom_range(0, 99) < 45);
                rx_data  = 8'($urandom);
                rx_error = ($urandom_range(0, 7) == 0);
                rd_en    = ($urandom_range(0, 99) < (10 + ph * 25));
                ovf_clr  = ($urandom_range(0, 31) == 0);
                rst      = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst = 1'b0; rd_en = 1'b0; rx_ready = 1'b0; ovf_clr = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the `uart` core. It captures each received byte together with its framing-error flag on the rising edge of the core's `rx_ready`, stores up to `DEPTH` entries, and presents them to the consumer through a first-word-fall-through read port. It reports occupancy flags and a sticky overflow flag, so bytes are not lost while the consumer is busy.

## Interface
- `DEPTH`, 8: number of entries; a power of 2, ≥ 2.
- `THRESH`, 4: `almost_full` asserts when `count >= THRESH`; 1 ≤ THRESH ≤ DEPTH.

- `clk` in 1: single clock; every register updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `rx_data` in 8: received byte from the `uart` core.
- `rx_ready` in 1: byte-valid from the core; may be a pulse or held high for several cycles.
- `rx_error` in 1: framing error for the byte, sampled together with `rx_ready`.
- `rd_en` in 1: consumer pop request.
- `rd_data` out 8: head entry byte; 8'h00 when empty.
- `rd_err` out 1: head entry error flag; 0 when empty.
- `empty` out 1: count == 0.
- `full` out 1: count == DEPTH.
- `count` out $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
- `almost_full` out 1: count ≥ THRESH.
- `overflow` out 1: sticky; set when a byte is dropped.
- `ovf_clr` in 1: clears `overflow`.

## Operation
- Edge detect:
  - `rx_ready_q` is a registered copy of `rx_ready`.
  - Write strobe `wr = rx_ready & ~rx_ready_q`.
  - A held-high `rx_ready` produces exactly one write.
  - `rx_ready_q` resets to 1, so a `rx_ready` that is already high when reset releases does not write.
- Entry format: 9 bits, {rx_error, rx_data}, both sampled in the `wr` cycle.
- Storage: circular buffer with write pointer `wp` and read pointer `rp`, each log2(DEPTH) bits, wrapping modulo DEPTH. `count` is a separate register.
- Pop: `rd = rd_en & ~empty`. A `rd_en` while empty is ignored and has no side effects.
- Push: `wr & (~full | rd)`.
  - When full and a pop happens in the same cycle, the write is accepted and `count` is unchanged.
- Drop: `wr & full & ~rd`. The byte is discarded, pointers and `count` are unchanged, and `overflow` sets.
- Simultaneous push and pop when not empty: both pointers advance and `count` is unchanged.
- Simultaneous `wr` and `rd_en` when empty: the write is accepted and the pop is ignored; `count` becomes 1.
- Overflow flag:
  - Set when a byte is dropped.
  - Cleared by `ovf_clr`.
  - If a set and `ovf_clr` occur in the same cycle, set wins.
- Read data: `rd_data` and `rd_err` are combinational from `mem[rp]`, gated to 0 when `empty`.

## Timing
- Reset (synchronous, held one or more cycles):
  - `wp = rp = 0`, `count = 0`, `overflow = 0`, `rx_ready_q = 1`.
  - Outputs: `empty = 1`, `full = 0`, `almost_full = 0`, `rd_data = 8'h00`, `rd_err = 0`.
  - Memory contents need not be reset.
- Reset mid-operation: all stored entries are discarded on the reset edge. No write occurs on that edge even if `wr` is active.
- Write latency: `rx_ready` is first sampled high at edge N. The entry is stored at edge N. `empty`, `count`, `rd_data` and `rd_err` reflect it after edge N, i.e. one cycle.
- Pop latency: `rd_en` is high with `~empty` at edge N. After edge N the next entry (or empty) is shown. A single cycle of `rd_en` pops exactly one entry.
- Flags: `empty`, `full`, `count` and `almost_full` are registered or derived from registered `count`. They have no combinational path from `rd_en` or `rx_ready`.
- Throughput: one write per two cycles at most, because `rx_ready` needs a low cycle for the next edge. One pop per cycle.

## Test plan
- Reset release with `rx_ready = 1` held → no write: `empty = 1`, `count = 0`. Then drop `rx_ready`, pulse it with `rx_data = 8'hA5`, `rx_error = 0` → one cycle later `rd_data = 8'hA5`, `rd_err = 0`, `count = 1`.
- Hold `rx_ready` high for 5 cycles with `rx_data = 8'h3C` → exactly one entry, `count = 1`.
- Write 8 bytes 8'h01..8'h08, with `rx_error = 1` on 8'h04 → `full = 1`, `almost_full = 1` from count 4. Then pop 8 → data is 01..08 in order, `rd_err = 1` only on 04, and `empty = 1` at the end.
- Fill to 8 and write 8'hFF without popping → dropped, `overflow = 1`, `count = 8`, head is still 8'h01.
  - Then assert `ovf_clr` in the same cycle as another drop → `overflow` stays 1.
  - `ovf_clr` alone → `overflow = 0`.
- Full FIFO, write 8'h99 with `rd_en` in the same cycle → pop of 8'h01, write accepted, `count = 8`, `overflow = 0`. Head-to-tail order becomes 02..08, 99; pointers wrap correctly.
- With `empty = 1`, pulse `rd_en` alone → no change. Then `wr` together with `rd_en` → `count = 1`. Then assert `rst` mid-fill → `count = 0`, `empty = 1`, `rd_data = 8'h00`.
